// File: rtl/data_mem_bytelane.sv
// rtl/data_mem_bytelane.sv - word-organised data memory with byte/half lanes, two-stage registered load port and post-reset clear
module data_mem_bytelane #(
    parameter int DEPTH     = 64,
    parameter int IDX_WIDTH = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] data_write,
    input  logic        write_en,
    input  logic        read_en,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    output logic [31:0] data_out,
    output logic        data_valid,
    output logic        busy,
    output logic        error
);
    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(DEPTH - 1);

    state_t               state_q;
    logic [IDX_WIDTH-1:0] clr_cnt_q;
    logic [31:0]          mem_q [DEPTH];
    logic                 rd_pend_q;
    logic                 err_pend_q;
    logic [31:0]          ld_data_q;
    logic [31:0]          data_out_q;
    logic                 data_valid_q;
    logic                 error_q;

    logic [31:0]          word_idx;
    logic                 in_range;
    logic                 align_ok;
    logic                 legal;
    logic                 ready;
    logic                 rd_ok;
    logic                 wr_ok;
    logic                 req_err;
    logic [IDX_WIDTH-1:0] idx;
    logic [31:0]          rd_word;
    logic [7:0]           byte_sel;
    logic [15:0]          half_sel;
    logic [31:0]          ld_data_d;
    logic [3:0]           be;
    logic [31:0]          wdata_rep;
    logic [31:0]          wr_word_d;

    always_comb begin
        word_idx = {2'b00, address[31:2]};
        in_range = word_idx < 32'(DEPTH);
        case (size)
            2'b00:   align_ok = 1'b1;
            2'b01:   align_ok = ~address[0];
            2'b10:   align_ok = (address[1:0] == 2'b00);
            default: align_ok = 1'b0;
        endcase
        legal   = align_ok & in_range;
        ready   = (state_q == ST_READY);
        rd_ok   = ready & read_en & legal;
        wr_ok   = ready & write_en & legal;
        req_err = ready & (read_en | write_en) & ~legal;
        idx     = address[IDX_WIDTH+1:2];
    end

    // Combinational read of the current word gives read-before-write on same-cycle hits.
    always_comb begin
        rd_word = mem_q[idx];
        case (address[1:0])
            2'b00:   byte_sel = rd_word[7:0];
            2'b01:   byte_sel = rd_word[15:8];
            2'b10:   byte_sel = rd_word[23:16];
            default: byte_sel = rd_word[31:24];
        endcase
        half_sel = address[1] ? rd_word[31:16] : rd_word[15:0];
        case (size)
            2'b00:   ld_data_d = {{24{byte_sel[7] & ~unsigned_ld}}, byte_sel};
            2'b01:   ld_data_d = {{16{half_sel[15] & ~unsigned_ld}}, half_sel};
            default: ld_data_d = rd_word;
        endcase
    end

    always_comb begin
        case (size)
            2'b00: begin
                be        = 4'b0001 << address[1:0];
                wdata_rep = {4{data_write[7:0]}};
            end
            2'b01: begin
                be        = address[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{data_write[15:0]}};
            end
            2'b10: begin
                be        = 4'b1111;
                wdata_rep = data_write;
            end
            default: begin
                be        = 4'b0000;
                wdata_rep = data_write;
            end
        endcase
        wr_word_d = rd_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) wr_word_d[8*i +: 8] = wdata_rep[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_CLEAR;
            clr_cnt_q    <= '0;
            rd_pend_q    <= 1'b0;
            err_pend_q   <= 1'b0;
            ld_data_q    <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            rd_pend_q    <= rd_ok;
            err_pend_q   <= req_err;
            if (rd_ok) ld_data_q <= ld_data_d;
            data_valid_q <= rd_pend_q;
            error_q      <= err_pend_q;
            if (rd_pend_q) data_out_q <= ld_data_q;
            case (state_q)
                ST_CLEAR: begin
                    mem_q[clr_cnt_q] <= '0;
                    clr_cnt_q        <= clr_cnt_q + IDX_WIDTH'(1);
                    if (clr_cnt_q == LAST_IDX) state_q <= ST_READY;
                end
                default: begin
                    if (wr_ok) mem_q[idx] <= wr_word_d;
                end
            endcase
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign error      = error_q;
    assign busy       = (state_q == ST_CLEAR);
endmodule

// File: tb/tb_data_mem_bytelane.sv
// tb/tb_data_mem_bytelane.sv - scoreboard bench for data_mem_bytelane
module tb_data_mem_bytelane;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] address = '0;
    logic [31:0] data_write = '0;
    logic        write_en = 1'b0;
    logic        read_en = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        unsigned_ld = 1'b0;
    logic [31:0] data_out;
    logic        data_valid;
    logic        busy;
    logic        error;

    always #5 clk = ~clk;

    data_mem_bytelane #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .data_write (data_write),
        .write_en   (write_en),
        .read_en    (read_en),
        .size       (size),
        .unsigned_ld(unsigned_ld),
        .data_out   (data_out),
        .data_valid (data_valid),
        .busy       (busy),
        .error      (error)
    );

    typedef struct {
        int          due;
        bit          is_err;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [DEPTH];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic bit is_legal(input logic [31:0] a, input logic [1:0] sz);
        if (sz == 2'b11) return 1'b0;
        if (sz == 2'b01 && a[0]) return 1'b0;
        if (sz == 2'b10 && a[1:0] != 2'b00) return 1'b0;
        return (a >> 2) < 32'(DEPTH);
    endfunction

    function automatic logic [31:0] ld_model(input logic [31:0] w, input logic [31:0] a,
                                             input logic [1:0] sz, input logic uns);
        logic [31:0] s;
        logic [1:0]  lane;
        lane = a[1:0];
        s = w >> (8 * lane);
        if (sz == 2'b00) return uns ? {24'h0, s[7:0]} : {{24{s[7]}}, s[7:0]};
        if (sz == 2'b01) return uns ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
        return w;
    endfunction

    function automatic logic [31:0] st_model(input logic [31:0] w, input logic [31:0] a,
                                             input logic [31:0] d, input logic [1:0] sz);
        logic [31:0] m;
        logic [1:0]  lane;
        lane = a[1:0];
        m = (sz == 2'b00) ? 32'h0000_00FF : (sz == 2'b01) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        return (w & ~(m << (8 * lane))) | ((d & m) << (8 * lane));
    endfunction

    // Called just after a falling edge; the request is sampled on the next rising edge.
    task automatic req(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input logic uns,
                       input bit has_exp = 1'b0, input logic [31:0] xexp = '0);
        exp_t e;
        int   wi;
        bit   ok;
        write_en = we; read_en = re; address = a; data_write = d; size = sz; unsigned_ld = uns;
        ok = is_legal(a, sz);
        if ((we || re) && !ok) begin
            e.due = cyc + 2; e.is_err = 1'b1; e.data = '0;
            sb.push_back(e);
        end else if (ok) begin
            wi = int'(a >> 2);
            if (re) begin
                e.due = cyc + 2; e.is_err = 1'b0;
                e.data = has_exp ? xexp : ld_model(model[wi], a, sz, uns);
                sb.push_back(e);
            end
            if (we) model[wi] = st_model(model[wi], a, d, sz);
        end
        @(negedge clk);
        write_en = 1'b0; read_en = 1'b0;
    endtask

    task automatic hit_reset();
        reset = 1'b1;
        write_en = 1'b0; read_en = 1'b0;
        sb.delete();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    // Releases reset and counts busy cycles, optionally hammering requests that must be ignored.
    task automatic release_and_count(input bit with_req);
        int n;
        reset = 1'b0;
        if (with_req) begin
            write_en = 1'b1; read_en = 1'b1; address = 32'h14;
            data_write = 32'hFFFF_FFFF; size = 2'b10;
        end
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        write_en = 1'b0; read_en = 1'b0;
        chk("busy_cycles", n, DEPTH);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                chk("valid", {31'b0, data_valid}, {31'b0, ~e.is_err});
                chk("error", {31'b0, error}, {31'b0, e.is_err});
                if (!e.is_err) chk("data", data_out, e.data);
            end else begin
                chk("idle_valid", {31'b0, data_valid}, 32'd0);
                chk("idle_error", {31'b0, error}, 32'd0);
            end
        end
    end

    initial begin
        logic [31:0] ra;
        logic [1:0]  rs;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_data_out", data_out, 32'h0);
        chk("rst_valid", {31'b0, data_valid}, 32'd0);
        chk("rst_error", {31'b0, error}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd1);
        mon_en = 1'b1;

        release_and_count(1'b1);
        req(0, 1, 32'h14, 0, 2'b10, 0, 1, 32'h0000_0000);

        req(1, 0, 32'h08, 32'h1122_3344, 2'b10, 0);
        req(1, 0, 32'h0A, 32'h0000_00AA, 2'b00, 0);
        req(0, 1, 32'h08, 0, 2'b10, 0, 1, 32'h11AA_3344);
        req(0, 1, 32'h0A, 0, 2'b00, 0, 1, 32'hFFFF_FFAA);
        req(0, 1, 32'h0A, 0, 2'b00, 1, 1, 32'h0000_00AA);
        req(0, 1, 32'h0A, 0, 2'b01, 0, 1, 32'h0000_11AA);
        req(1, 0, 32'h0E, 32'h1234_8001, 2'b01, 0);
        req(0, 1, 32'h0E, 0, 2'b01, 0, 1, 32'hFFFF_8001);
        req(0, 1, 32'h0C, 0, 2'b10, 0, 1, 32'h8001_0000);
        req(0, 1, 32'h0E, 0, 2'b01, 1, 1, 32'h0000_8001);

        req(1, 0, 32'h06, 32'hCAFE_F00D, 2'b10, 0);
        req(0, 1, 32'h03, 0, 2'b01, 0);
        req(0, 1, 32'h08, 0, 2'b11, 0);
        req(1, 0, 32'h08, 32'h5555_5555, 2'b11, 0);
        req(0, 1, 32'h100, 0, 2'b10, 0);
        req(1, 0, 32'h100, 32'h7777_7777, 2'b00, 0);
        req(0, 1, 32'h04, 0, 2'b10, 0, 1, 32'h0000_0000);
        req(0, 1, 32'h08, 0, 2'b10, 0, 1, 32'h11AA_3344);
        req(1, 0, 32'hFC, 32'hA5A5_5A5A, 2'b10, 0);
        req(0, 1, 32'hFF, 0, 2'b00, 1, 1, 32'h0000_00A5);

        req(1, 1, 32'h10, 32'hDEAD_BEEF, 2'b10, 0, 1, 32'h0000_0000);
        req(0, 1, 32'h10, 0, 2'b10, 0, 1, 32'hDEAD_BEEF);

        for (int i = 0; i < 300; i++) begin
            ra = 32'($urandom_range(0, 4 * DEPTH + 15));
            rs = 2'($urandom_range(0, 3));
            req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, $urandom(), rs,
                1'($urandom_range(0, 1)));
        end

        req(1, 0, 32'h10, 32'hDEAD_BEEF, 2'b10, 0);
        req(0, 1, 32'h10, 0, 2'b10, 0);
        hit_reset();
        repeat (2) @(negedge clk);
        chk("rst_busy_mid", {31'b0, busy}, 32'd1);
        chk("rst_data_out_mid", data_out, 32'h0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("busy_at_20", {31'b0, busy}, 32'd1);
        hit_reset();
        repeat (2) @(negedge clk);
        release_and_count(1'b0);
        for (int i = 0; i < DEPTH; i++) req(0, 1, 32'(4 * i), 0, 2'b10, 0, 1, 32'h0000_0000);

        repeat (4) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
